// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: access-size and FSM state encodings shared by the load/store unit,
// plus the store byte-lane enable helper.
package mem_lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_RSVD = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   function automatic logic [3:0] byteEnable(input size_e size, input logic [1:0] offset);
      logic [3:0] mask;
      case (size)
         SZ_BYTE: mask = 4'b0001 << offset;
         SZ_HALF: mask = 4'b0011 << offset;
         default: mask = 4'b1111;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/mem_lsu_extract.sv
// mem_lsu_extract: picks the addressed byte/half/word lane out of a RAM word and
// zero- or sign-extends it to 32 bits (purely combinational).
module mem_lsu_extract
   import mem_lsu_pkg::*;
(
   input  logic [31:0] i_memDout,
   input  logic [1:0]  i_offset,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Halves only ever sit on lane 0 or lane 2, so only offset[1] steers them.
   always_comb begin
      w_byte = i_memDout[{i_offset, 3'b000} +: 8];
      w_half = i_memDout[{i_offset[1], 4'b0000} +: 16];
      case (size_e'(i_size))
         SZ_BYTE: o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
         SZ_HALF: o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
         default: o_data = i_memDout;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: single-port RAM load/store unit (IDLE -> ACCESS -> RESP).
// Optional MEM_LSU_MISALIGN_CHECK_EN rejects misaligned/reserved accesses with rsp_err.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH+1:0] req_addr,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_en,
   output logic [3:0]            mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   state_e                r_state;
   logic [1:0]            r_offset;
   size_e                 r_size;
   logic                  r_unsigned;
   logic                  r_we;
   logic                  r_rspValid;
   logic [DATA_WIDTH-1:0] r_rdata;
`ifdef MEM_LSU_MISALIGN_CHECK_EN
   logic                  r_err;
`endif

   size_e                 w_size;
   logic [1:0]            w_offset;
   logic                  w_misalign;
   logic                  w_accept;
   logic [31:0]           w_extData;

   // Normalise the request: either flag illegal alignment, or silently align it.
   always_comb begin
      w_size     = size_e'(req_size);
      w_offset   = req_addr[1:0];
      w_misalign = 1'b0;
`ifdef MEM_LSU_MISALIGN_CHECK_EN
      case (w_size)
         SZ_HALF: w_misalign = req_addr[0];
         SZ_WORD: w_misalign = (req_addr[1:0] != 2'b00);
         SZ_RSVD: w_misalign = 1'b1;
         default: w_misalign = 1'b0;
      endcase
`else
      case (w_size)
         SZ_HALF: w_offset = {req_addr[1], 1'b0};
         SZ_WORD, SZ_RSVD: begin
            w_size   = SZ_WORD;
            w_offset = 2'b00;
         end
         default: ;
      endcase
`endif
   end

   assign req_ready = rst_n && (r_state == ST_IDLE);
   assign w_accept  = req_valid && req_ready;
   assign mem_en    = w_accept && !w_misalign;
   assign mem_we    = (mem_en && req_we) ? byteEnable(w_size, w_offset) : 4'b0000;
   assign mem_addr  = req_addr[ADDR_WIDTH+1:2];

   always_comb begin
      case (w_size)
         SZ_BYTE: mem_din = {4{req_wdata[7:0]}};
         SZ_HALF: mem_din = {2{req_wdata[15:0]}};
         default: mem_din = req_wdata;
      endcase
   end

   mem_lsu_extract u_extract (
      .i_memDout (mem_dout),
      .i_offset  (r_offset),
      .i_size    (r_size),
      .i_unsigned(r_unsigned),
      .o_data    (w_extData)
   );

   // Response data is captured at the end of ACCESS, when mem_dout holds the read word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_offset   <= 2'b00;
         r_size     <= SZ_BYTE;
         r_unsigned <= 1'b0;
         r_we       <= 1'b0;
         r_rspValid <= 1'b0;
         r_rdata    <= '0;
`ifdef MEM_LSU_MISALIGN_CHECK_EN
         r_err      <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_offset   <= w_offset;
                  r_size     <= w_size;
                  r_unsigned <= req_unsigned;
                  r_we       <= req_we;
`ifdef MEM_LSU_MISALIGN_CHECK_EN
                  if (w_misalign) begin
                     r_state    <= ST_RESP;
                     r_rspValid <= 1'b1;
                     r_rdata    <= '0;
                     r_err      <= 1'b1;
                  end else begin
                     r_state    <= ST_ACCESS;
                     r_err      <= 1'b0;
                  end
`else
                  r_state <= ST_ACCESS;
`endif
               end
            end
            ST_ACCESS: begin
               r_rdata    <= r_we ? '0 : w_extData;
               r_rspValid <= 1'b1;
               r_state    <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rspValid <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rsp_valid = r_rspValid;
   assign rsp_rdata = r_rdata;
`ifdef MEM_LSU_MISALIGN_CHECK_EN
   assign rsp_err   = r_err;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule
